// File: rtl/fifo_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_merge
// Purpose  : Round-robin merge of NUM_PORTS source streams into one framed
//            output stream: header {port, count}, then up to MAX_BURST words.
// Option   : define FIFO_RR_MERGE_CHECKSUM_EN to append an XOR trailer word.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_merge #(
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 2,
  parameter int MAX_BURST = 16,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       in_fifos_enable,
  input  logic [NUM_PORTS*WIDTH-1:0] in_fifos_data,
  output logic [NUM_PORTS-1:0]       in_fifos_ready,
  output logic                       out_fifo_enable,
  output logic [WIDTH-1:0]           out_fifo_data,
  input  logic                       out_fifo_ready,
  output logic                       busy,
  output logic [PW-1:0]              cur_port
);

  localparam int           AW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  localparam logic [PW:0]   NP   = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_HEADER   = 3'd2;
  localparam logic [2:0] S_PAYLOAD  = 3'd3;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
  localparam logic [2:0] S_CHECKSUM = 3'd4;
`endif

  if (PW + CW > WIDTH) begin : g_cfg_check
    $error("fifo_rr_merge: header fields do not fit in WIDTH");
  end

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    sel_q, sel_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             out_enable_q, out_enable_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] buf_q [MAX_BURST];
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;
`endif

  logic [NUM_PORTS-1:0] w_req_rot;
  logic                 w_found;
  logic [PW-1:0]        w_offset;
  logic [PW:0]          w_sum;
  logic [PW-1:0]        w_grant;
  logic [PW-1:0]        w_next_ptr;
  logic                 w_sel_enable;
  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_buf_we;

  function automatic logic [WIDTH-1:0] f_header(input logic [PW-1:0] p,
                                                input logic [CW-1:0] c);
    return WIDTH'({p, c});
  endfunction

  // Rotate requests so bit 0 is the port at rr_ptr; lowest set bit wins.
  assign w_req_rot  = NUM_PORTS'({in_fifos_enable, in_fifos_enable} >> rr_ptr_q);
  assign w_sum      = {1'b0, rr_ptr_q} + {1'b0, w_offset};
  assign w_grant    = (w_sum >= NP) ? PW'(w_sum - NP) : PW'(w_sum);
  assign w_next_ptr = (sel_q == LAST) ? '0 : sel_q + PW'(1);

  always_comb begin
    w_found  = 1'b0;
    w_offset = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_found  = 1'b1;
        w_offset = PW'(i);
      end
    end
  end

  always_comb begin
    w_sel_enable   = 1'b0;
    w_sel_data     = '0;
    in_fifos_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_q == PW'(i)) begin
        w_sel_enable      = in_fifos_enable[i];
        w_sel_data        = in_fifos_data[i*WIDTH +: WIDTH];
        in_fifos_ready[i] = (state_q == S_COLLECT) && (count_q < MAXC);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sel_d        = sel_q;
    count_d      = count_q;
    idx_d        = idx_q;
    out_enable_d = out_enable_q;
    out_data_d   = out_data_q;
    w_buf_we     = 1'b0;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          sel_d   = w_grant;
          count_d = '0;
          state_d = S_COLLECT;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (w_sel_enable && (count_q < MAXC)) begin
          w_buf_we = 1'b1;
          count_d  = count_q + CW'(1);
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
          csum_d   = csum_q ^ w_sel_data;
`endif
          if (count_d == MAXC) begin
            state_d      = S_HEADER;
            out_enable_d = 1'b1;
            out_data_d   = f_header(sel_q, count_d);
          end
        end else if (!w_sel_enable) begin
          // A source that withdrew before sending anything yields its turn.
          if (count_q == '0) begin
            state_d  = S_IDLE;
            rr_ptr_d = w_next_ptr;
          end else begin
            state_d      = S_HEADER;
            out_enable_d = 1'b1;
            out_data_d   = f_header(sel_q, count_q);
          end
        end
      end
      S_HEADER: begin
        if (out_fifo_ready) begin
          state_d    = S_PAYLOAD;
          idx_d      = '0;
          out_data_d = buf_q[0];
        end
      end
      S_PAYLOAD: begin
        if (out_fifo_ready) begin
          if (CW'(idx_q) == count_q - CW'(1)) begin
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
            state_d      = S_CHECKSUM;
            out_data_d   = csum_q;
`else
            state_d      = S_IDLE;
            out_enable_d = 1'b0;
            rr_ptr_d     = w_next_ptr;
            count_d      = '0;
`endif
          end else begin
            idx_d      = idx_q + AW'(1);
            out_data_d = buf_q[idx_q + AW'(1)];
          end
        end
      end
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
      S_CHECKSUM: begin
        if (out_fifo_ready) begin
          state_d      = S_IDLE;
          out_enable_d = 1'b0;
          rr_ptr_d     = w_next_ptr;
          count_d      = '0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      out_enable_q <= 1'b0;
      out_data_q   <= '0;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      out_enable_q <= out_enable_d;
      out_data_q   <= out_data_d;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Buffer contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      buf_q[count_q[AW-1:0]] <= w_sel_data;
    end
  end

  assign out_fifo_enable = out_enable_q;
  assign out_fifo_data   = out_data_q;
  assign busy            = (state_q != S_IDLE);
  assign cur_port        = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_merge
// Purpose  : Self-checking bench: vector table, hand sequences and randomized
//            streams compared against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_merge;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int MB = 16;
  localparam int CW = 5;
`ifdef FIFO_RR_MERGE_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    int               len0;
    int               len1;
    logic [7:0]       start0;
    logic [7:0]       start1;
    logic [7:0]       step;
    int               nhdr;
    logic [3:0][7:0]  hdr;
    int               rdy_mode;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   in_en = '0;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_data = '0;
  logic           out_en;
  logic           out_rdy = 1'b1;
  logic [W-1:0]   out_data;
  logic           busy;
  logic [0:0]     cur_port;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] src_mem [N][64];
  int         src_rd [N];
  int         src_wr [N];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         rdy_mode = 0;
  int         m_rr = 0;

  fifo_rr_merge #(.WIDTH(W), .NUM_PORTS(N), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_fifos_enable (in_en),
    .in_fifos_data   (in_data),
    .in_fifos_ready  (in_rdy),
    .out_fifo_enable (out_en),
    .out_fifo_data   (out_data),
    .out_fifo_ready  (out_rdy),
    .busy            (busy),
    .cur_port        (cur_port)
  );

  always #5 clk = ~clk;

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sources stream their queues back-to-back; the sink follows rdy_mode.
  initial begin : p_bfm
    logic [N-1:0] fire;
    logic         ofire;
    logic         hold_pend;
    logic [7:0]   hold_data;
    int           pat;
    hold_pend = 1'b0;
    hold_data = '0;
    pat       = 0;
    for (int p = 0; p < N; p++) begin
      src_rd[p] = 0;
      src_wr[p] = 0;
    end
    forever begin
      @(negedge clk);
      fire  = in_en & in_rdy;
      ofire = out_en & out_rdy;
      if (reset) begin
        hold_pend = 1'b0;
        fire      = '0;
        ofire     = 1'b0;
      end else begin
        if (hold_pend) begin
          chk_v("hold_enable", 32'(out_en), 32'd1);
          chk_v("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_pend = out_en && !out_rdy;
        hold_data = out_data;
        if (out_en) chk_v("ready_while_framing", 32'(in_rdy), 32'd0);
        if (ofire) got_q.push_back(out_data);
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) if (fire[p]) src_rd[p]++;
      for (int p = 0; p < N; p++) begin
        in_en[p] = (src_rd[p] < src_wr[p]);
        in_data[p*W +: W] = in_en[p] ? src_mem[p][src_rd[p]] : 8'h00;
      end
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ($urandom_range(0, 9) < 7);
        default: begin
          out_rdy = (pat == 0);
          pat = (pat + 1) % 3;
        end
      endcase
    end
  end

  task automatic load_port(input int p, input int len, input logic [7:0] start,
                           input logic [7:0] step, input bit rnd);
    for (int k = 0; k < len; k++)
      src_mem[p][k] = rnd ? 8'($urandom) : 8'(start + 8'(k) * step);
    src_rd[p] = 0;
    src_wr[p] = len;
  endtask

  // Packet-level model: each grant takes min(remaining, MB) words from the
  // first non-empty port at or after the round-robin pointer.
  task automatic model_build();
    int rem [N];
    int pos [N];
    int p;
    int n;
    logic [7:0] x;
    for (int i = 0; i < N; i++) begin
      rem[i] = src_wr[i] - src_rd[i];
      pos[i] = src_rd[i];
    end
    while (1'b1) begin
      p = -1;
      for (int i = 0; i < N; i++)
        if (p < 0 && rem[(m_rr + i) % N] > 0) p = (m_rr + i) % N;
      if (p < 0) break;
      n = (rem[p] < MB) ? rem[p] : MB;
      exp_q.push_back(8'((p << CW) | n));
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(src_mem[p][pos[p] + k]);
        x = x ^ src_mem[p][pos[p] + k];
      end
      if (CHK != 0) exp_q.push_back(x);
      pos[p] += n;
      rem[p] -= n;
      m_rr = (p + 1) % N;
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((got_q.size() < exp_q.size() || busy) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (5) @(posedge clk);
    #2;
    chk_v("drain_in_budget", 32'(c < 3000), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    chk_v({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk_v($sformatf("%s_w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : p_main
    vec_t       tv [6];
    int         pos;
    int         h;
    int         c;
    logic [7:0] hv;

    tv[0] = '{len0:0,  len1:3,  start0:8'h00, start1:8'h11, step:8'h11, nhdr:1,
              hdr:{8'h00, 8'h00, 8'h00, 8'h23}, rdy_mode:0};
    tv[1] = '{len0:2,  len1:2,  start0:8'hA0, start1:8'hB0, step:8'h01, nhdr:2,
              hdr:{8'h00, 8'h00, 8'h22, 8'h02}, rdy_mode:0};
    tv[2] = '{len0:20, len1:0,  start0:8'h00, start1:8'h00, step:8'h01, nhdr:2,
              hdr:{8'h00, 8'h00, 8'h04, 8'h10}, rdy_mode:2};
    tv[3] = '{len0:20, len1:20, start0:8'h40, start1:8'h80, step:8'h01, nhdr:4,
              hdr:{8'h04, 8'h24, 8'h10, 8'h30}, rdy_mode:1};
    tv[4] = '{len0:1,  len1:0,  start0:8'hAB, start1:8'h00, step:8'h01, nhdr:1,
              hdr:{8'h00, 8'h00, 8'h00, 8'h01}, rdy_mode:0};
    tv[5] = '{len0:16, len1:16, start0:8'h01, start1:8'hF0, step:8'h03, nhdr:2,
              hdr:{8'h00, 8'h00, 8'h10, 8'h30}, rdy_mode:0};

    // Reset and idle
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_v("rst_ready", 32'(in_rdy), 32'd0);
    chk_v("rst_out_enable", 32'(out_en), 32'd0);
    chk_v("rst_out_data", 32'(out_data), 32'd0);
    chk_v("rst_busy", 32'(busy), 32'd0);
    chk_v("rst_cur_port", 32'(cur_port), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk_v("idle_ready", 32'(in_rdy), 32'd0);
      chk_v("idle_out_enable", 32'(out_en), 32'd0);
      chk_v("idle_busy", 32'(busy), 32'd0);
    end

    // Vector table
    for (int t = 0; t < 6; t++) begin
      @(posedge clk);
      #2;
      rdy_mode = tv[t].rdy_mode;
      load_port(0, tv[t].len0, tv[t].start0, tv[t].step, 1'b0);
      load_port(1, tv[t].len1, tv[t].start1, tv[t].step, 1'b0);
      model_build();
      wait_drain();
      pos = 0;
      h   = 0;
      while (pos < got_q.size() && h < 4) begin
        hv = got_q[pos];
        if (h < tv[t].nhdr)
          chk_v($sformatf("vec%0d_hdr%0d", t, h), 32'(hv), 32'(tv[t].hdr[h]));
        pos += 1 + int'(hv[CW-1:0]) + CHK;
        h++;
      end
      chk_v($sformatf("vec%0d_npkt", t), 32'(h), 32'(tv[t].nhdr));
      compare_stream($sformatf("vec%0d", t));
    end

    // Reset after five words collected from port 1: nothing may be emitted
    @(posedge clk);
    #2;
    rdy_mode = 0;
    load_port(1, 10, 8'h50, 8'h01, 1'b0);
    c = 0;
    while (src_rd[1] < 5 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk_v("midrst_collected", 32'(src_rd[1]), 32'd5);
    reset = 1'b1;
    src_wr[1] = src_rd[1];
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    m_rr = 0;
    repeat (20) @(posedge clk);
    #2;
    chk_v("midrst_no_output", 32'(got_q.size()), 32'd0);
    chk_v("midrst_busy", 32'(busy), 32'd0);
    chk_v("midrst_cur_port", 32'(cur_port), 32'd0);
    got_q.delete();
    load_port(0, 1, 8'h5A, 8'h00, 1'b0);
    load_port(1, 1, 8'hA5, 8'h00, 1'b0);
    model_build();
    wait_drain();
    compare_stream("midrst_rr");

    // Randomized streams with random sink backpressure
    for (int r = 0; r < 6; r++) begin
      @(posedge clk);
      #2;
      rdy_mode = 1;
      load_port(0, $urandom_range(0, 40), 8'h00, 8'h00, 1'b1);
      load_port(1, $urandom_range(0, 40), 8'h00, 8'h00, 1'b1);
      model_build();
      wait_drain();
      compare_stream($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
